// File: rtl/cla32_add_seq.sv
// ---------------------------------------------------------------------------
// cla32_add_seq
//
// Sequential operand/result stage wrapped around an external 32-bit
// carry-lookahead adder. A request is accepted over a valid/ready handshake,
// the adder inputs are driven from registers for one settle cycle, and the
// sum plus carry-out/overflow/zero flags are then captured and held until
// the consumer takes them. A 32-bit accumulator allows chained additions.
//
// Handshake semantics (both sides): a transfer happens on a rising clk edge
// where valid and ready are both high. The stage only raises in_ready in
// IDLE and only raises out_valid in DONE. Once out_valid is high, out_* stay
// stable until the edge on which out_ready is seen high.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   request handshake
//   in_a, in_b, in_cin  operands and carry-in (sampled only at accept)
//   in_mode             0=ADD, 1=SUB, 2=ACC (acc+B+cin), 3=ADD
//   acc_clr             synchronous accumulator clear (wins over ACC load)
//   add_a/add_b/add_cin registered adder inputs
//   add_s/add_gp/add_gg adder sum and group propagate/generate
//   out_valid/out_ready result handshake
//   out_sum, out_cout, out_ovf, out_zero   registered result and flags
//   acc                 accumulator contents
// ---------------------------------------------------------------------------
module cla32_add_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic        in_cin,
    input  logic [1:0]  in_mode,
    input  logic        acc_clr,
    output logic [31:0] add_a,
    output logic [31:0] add_b,
    output logic        add_cin,
    input  logic [31:0] add_s,
    input  logic        add_gp,
    input  logic        add_gg,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_sum,
    output logic        out_cout,
    output logic        out_ovf,
    output logic        out_zero,
    output logic [31:0] acc
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] add_a_q, add_a_d;
    logic [31:0] add_b_q, add_b_d;
    logic        add_cin_q, add_cin_d;
    logic        is_acc_q, is_acc_d;
    logic [31:0] sum_q, sum_d;
    logic        cout_q, cout_d;
    logic        ovf_q, ovf_d;
    logic        zero_q, zero_d;
    logic [31:0] acc_q, acc_d;

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (in_valid) state_d = S_EXEC;
            S_EXEC:  state_d = S_DONE;
            S_DONE:  if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Operand latching at the accept edge
    always_comb begin
        add_a_d   = add_a_q;
        add_b_d   = add_b_q;
        add_cin_d = add_cin_q;
        is_acc_d  = is_acc_q;
        if (state_q == S_IDLE && in_valid) begin
            case (in_mode)
                2'd1: begin
                    // Two's-complement subtract: a + ~b + 1
                    add_a_d   = in_a;
                    add_b_d   = ~in_b;
                    add_cin_d = 1'b1;
                    is_acc_d  = 1'b0;
                end
                2'd2: begin
                    // Uses the accumulator value as it stands at this edge,
                    // even if acc_clr is asserted on the same edge.
                    add_a_d   = acc_q;
                    add_b_d   = in_b;
                    add_cin_d = in_cin;
                    is_acc_d  = 1'b1;
                end
                default: begin
                    add_a_d   = in_a;
                    add_b_d   = in_b;
                    add_cin_d = in_cin;
                    is_acc_d  = 1'b0;
                end
            endcase
        end
    end

    // Result capture at the end of the settle cycle
    always_comb begin
        sum_d  = sum_q;
        cout_d = cout_q;
        ovf_d  = ovf_q;
        zero_d = zero_q;
        if (state_q == S_EXEC) begin
            sum_d  = add_s;
            cout_d = add_gg | (add_gp & add_cin_q);
            ovf_d  = (add_a_q[31] == add_b_q[31]) && (add_s[31] != add_a_q[31]);
            zero_d = (add_s == 32'd0);
        end
    end

    // Accumulator: clear has priority over an ACC load; carry is dropped.
    always_comb begin
        acc_d = acc_q;
        if (acc_clr) begin
            acc_d = 32'd0;
        end else if (state_q == S_EXEC && is_acc_q) begin
            acc_d = add_s;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            add_a_q   <= 32'd0;
            add_b_q   <= 32'd0;
            add_cin_q <= 1'b0;
            is_acc_q  <= 1'b0;
            sum_q     <= 32'd0;
            cout_q    <= 1'b0;
            ovf_q     <= 1'b0;
            zero_q    <= 1'b1;
            acc_q     <= 32'd0;
        end else begin
            state_q   <= state_d;
            add_a_q   <= add_a_d;
            add_b_q   <= add_b_d;
            add_cin_q <= add_cin_d;
            is_acc_q  <= is_acc_d;
            sum_q     <= sum_d;
            cout_q    <= cout_d;
            ovf_q     <= ovf_d;
            zero_q    <= zero_d;
            acc_q     <= acc_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign add_a     = add_a_q;
    assign add_b     = add_b_q;
    assign add_cin   = add_cin_q;
    assign out_sum   = sum_q;
    assign out_cout  = cout_q;
    assign out_ovf   = ovf_q;
    assign out_zero  = zero_q;
    assign acc       = acc_q;

endmodule

// File: tb/tb_cla32_add_seq.sv
// ---------------------------------------------------------------------------
// tb_cla32_add_seq
//
// Directed bench for cla32_add_seq. A behavioural 32-bit adder supplies
// add_s/add_gp/add_gg from the DUT's registered adder inputs. Inputs are
// driven on the falling edge, outputs sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_cla32_add_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        in_cin;
    logic [1:0]  in_mode;
    logic        acc_clr;
    logic [31:0] add_a;
    logic [31:0] add_b;
    logic        add_cin;
    logic [31:0] add_s;
    logic        add_gp;
    logic        add_gg;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_sum;
    logic        out_cout;
    logic        out_ovf;
    logic        out_zero;
    logic [31:0] acc;

    int errors = 0;
    int checks = 0;

    cla32_add_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .in_mode   (in_mode),
        .acc_clr   (acc_clr),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_s     (add_s),
        .add_gp    (add_gp),
        .add_gg    (add_gg),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf),
        .out_zero  (out_zero),
        .acc       (acc)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural carry-lookahead adder
    logic [32:0] gen_sum;
    always_comb begin
        add_s   = add_a + add_b + {31'd0, add_cin};
        gen_sum = {1'b0, add_a} + {1'b0, add_b};
        add_gg  = gen_sum[32];
        add_gp  = &(add_a ^ add_b);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Presents a request and returns at the falling edge of the EXEC cycle.
    task automatic issue(input logic [1:0] m, input logic [31:0] a, input logic [31:0] b,
                         input logic c);
        in_valid = 1'b1;
        in_mode  = m;
        in_a     = a;
        in_b     = b;
        in_cin   = c;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        // Later input changes must not disturb the in-flight operation
        in_a     = $urandom;
        in_b     = $urandom;
        in_cin   = 1'(($urandom_range(0, 1)));
        in_mode  = 2'(($urandom_range(0, 3)));
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_result(input string tag, input logic [31:0] s, input logic co,
                                input logic ov, input logic z);
        check({tag, ".valid"}, out_valid, 1'b1);
        check({tag, ".sum"},   out_sum, s);
        check({tag, ".cout"},  out_cout, co);
        check({tag, ".ovf"},   out_ovf, ov);
        check({tag, ".zero"},  out_zero, z);
    endtask

    initial begin
        logic [31:0] acc_m, am, bm, s_m;
        logic [32:0] full;
        logic [1:0]  m;
        logic        cm, ovf_m;
        int          hold;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = 32'd0;
        in_b      = 32'd0;
        in_cin    = 1'b0;
        in_mode   = 2'd0;
        acc_clr   = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst.in_ready", in_ready, 1'b1);
        check("rst.out_valid", out_valid, 1'b0);
        check("rst.out_sum", out_sum, 32'd0);
        check("rst.out_zero", out_zero, 1'b1);
        check("rst.flags", {30'd0, out_cout, out_ovf}, 32'd0);
        check("rst.acc", acc, 32'd0);
        check("rst.add_a", add_a, 32'd0);
        check("rst.add_b", add_b, 32'd0);
        check("rst.add_cin", add_cin, 1'b0);
        rst_n = 1'b1;
        step();

        // ADD wrap-around: 0xFFFFFFFF + 1
        issue(2'd0, 32'hFFFF_FFFF, 32'h1, 1'b0);
        check("add1.exec_valid", out_valid, 1'b0);
        check("add1.exec_ready", in_ready, 1'b0);
        check("add1.add_a", add_a, 32'hFFFF_FFFF);
        check("add1.add_b", add_b, 32'h1);
        check("add1.add_cin", add_cin, 1'b0);
        step();
        check_result("add1", 32'h0, 1'b1, 1'b0, 1'b1);
        check("add1.done_ready", in_ready, 1'b0);
        step();
        check("add1.idle_valid", out_valid, 1'b0);
        check("add1.idle_ready", in_ready, 1'b1);

        // SUB 0x80000000 - 1: signed overflow
        issue(2'd1, 32'h8000_0000, 32'h1, 1'b0);
        check("sub1.add_b", add_b, 32'hFFFF_FFFE);
        check("sub1.add_cin", add_cin, 1'b1);
        step();
        check_result("sub1", 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
        step();

        // ADD 0x7FFFFFFF + 0x7FFFFFFF: positive overflow
        issue(2'd0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0);
        step();
        check_result("add2", 32'hFFFF_FFFE, 1'b0, 1'b1, 1'b0);
        step();

        // Reserved mode 3 behaves as ADD with carry-in
        issue(2'd3, 32'd10, 32'd20, 1'b1);
        check("rsv.add_cin", add_cin, 1'b1);
        step();
        check_result("rsv", 32'd31, 1'b0, 1'b0, 1'b0);
        step();

        // SUB ignores in_cin: 10 - 3
        issue(2'd1, 32'd10, 32'd3, 1'b0);
        step();
        check_result("sub2", 32'd7, 1'b1, 1'b0, 1'b0);
        step();

        // Accumulator chain
        acc_clr = 1'b1;
        step();
        acc_clr = 1'b0;
        check("clr.acc", acc, 32'd0);
        issue(2'd2, 32'hDEAD_BEEF, 32'd5, 1'b0);
        check("acc1.add_a", add_a, 32'd0);
        step();
        check_result("acc1", 32'd5, 1'b0, 1'b0, 1'b0);
        check("acc1.acc", acc, 32'd5);
        step();
        issue(2'd2, 32'h1234_5678, 32'd7, 1'b1);
        check("acc2.add_a", add_a, 32'd5);
        step();
        check_result("acc2", 32'd13, 1'b0, 1'b0, 1'b0);
        check("acc2.acc", acc, 32'd13);
        step();
        // Clear during EXEC of a third ACC wins over the load
        issue(2'd2, 32'd0, 32'd2, 1'b0);
        acc_clr = 1'b1;
        step();
        acc_clr = 1'b0;
        check_result("acc3", 32'd15, 1'b0, 1'b0, 1'b0);
        check("acc3.acc", acc, 32'd0);
        step();

        // Backpressure with a new request held upstream
        out_ready = 1'b0;
        issue(2'd0, 32'd1, 32'd2, 1'b0);
        step();
        in_valid = 1'b1;
        in_mode  = 2'd0;
        in_a     = 32'd100;
        in_b     = 32'd200;
        in_cin   = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check_result("bp.hold", 32'd3, 1'b0, 1'b0, 1'b0);
            check("bp.in_ready", in_ready, 1'b0);
            step();
        end
        out_ready = 1'b1;
        step();
        check("bp.rel_valid", out_valid, 1'b0);
        check("bp.rel_ready", in_ready, 1'b1);
        step();
        in_valid = 1'b0;
        check("bp.acc_ready", in_ready, 1'b0);
        check("bp.add_a", add_a, 32'd100);
        step();
        check_result("bp.new", 32'd300, 1'b0, 1'b0, 1'b0);
        step();

        // Reset during EXEC drops the pending result and clears acc
        issue(2'd2, 32'd0, 32'd9, 1'b0);
        step();
        check("pre_rst.acc", acc, 32'd9);
        step();
        issue(2'd0, 32'd3, 32'd4, 1'b0);
        rst_n = 1'b0;
        #2;
        check("mid_rst.valid", out_valid, 1'b0);
        check("mid_rst.ready", in_ready, 1'b1);
        check("mid_rst.acc", acc, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("post_rst.valid", out_valid, 1'b0);
            check("post_rst.ready", in_ready, 1'b1);
            step();
        end
        check("post_rst.out_zero", out_zero, 1'b1);

        // Randomized mixed traffic against a reference model
        acc_m = 32'd0;
        for (int n = 0; n < 24; n++) begin
            m  = 2'(($urandom_range(0, 2)));
            am = $urandom;
            bm = $urandom;
            cm = 1'(($urandom_range(0, 1)));
            issue(m, am, bm, cm);
            if (m == 2'd2) am = acc_m;
            if (m == 2'd1) begin
                bm = ~bm;
                cm = 1'b1;
            end
            full  = {1'b0, am} + {1'b0, bm} + {32'd0, cm};
            s_m   = full[31:0];
            ovf_m = (am[31] == bm[31]) && (s_m[31] != am[31]);
            if (m == 2'd2) acc_m = s_m;
            out_ready = 1'b0;
            step();
            hold = $urandom_range(0, 3);
            for (int k = 0; k <= hold; k++) begin
                check_result("rnd", s_m, full[32], ovf_m, (s_m == 32'd0));
                check("rnd.acc", acc, acc_m);
                if (k < hold) step();
            end
            out_ready = 1'b1;
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cla32_add_seq.md
# cla32_add_seq

Sequential operand/result stage wrapped around the 32-bit carry-lookahead adder. It accepts operand pairs over a valid/ready handshake and drives the registered adder inputs for one settle cycle. It then captures the sum, carry-out (from the adder's group propagate/generate), overflow and zero flags, and holds the result until the downstream consumer takes it. It also keeps a 32-bit accumulator so repeated additions can be chained without re-sending the running total.

## Interface
- No parameters; datapath width is fixed at 32.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand request valid
- in_ready  out  1  stage can accept a request
- in_a  in  32  operand A (ignored in ACC mode)
- in_b  in  32  operand B
- in_cin  in  1  carry-in (ADD and ACC modes only)
- in_mode  in  2  0=ADD, 1=SUB, 2=ACC (acc + B + cin), 3=reserved (treated as ADD)
- acc_clr  in  1  synchronous clear of accumulator
- add_a  out  32  to adder operand a
- add_b  out  32  to adder operand b
- add_cin  out  1  to adder carry-in
- add_s  in  32  adder sum
- add_gp  in  1  adder group propagate
- add_gg  in  1  adder group generate
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_sum  out  32  registered sum
- out_cout  out  1  carry-out = add_gg | (add_gp & add_cin)
- out_ovf  out  1  signed overflow
- out_zero  out  1  out_sum == 0
- acc  out  32  accumulator contents

## Operation
- FSM states: IDLE, EXEC, DONE.
- IDLE: in_ready=1. If in_valid is high at a clock edge, latch the operands into the adder input registers and go to EXEC.
- Operand latching by mode:
  - ADD: add_a=in_a, add_b=in_b, add_cin=in_cin.
  - SUB: add_a=in_a, add_b=~in_b, add_cin=1.
  - ACC: add_a=acc, add_b=in_b, add_cin=in_cin.
- EXEC: the adder settles from the registered inputs. At the edge, capture out_sum=add_s, out_cout, out_ovf, out_zero. If the mode was ACC, also load acc=add_s. Go to DONE.
- out_ovf = (add_a[31]==add_b[31]) & (add_s[31]!=add_a[31]), evaluated on the registered add_a/add_b.
- DONE: out_valid=1 and all out_* signals are held stable. If out_ready is high at an edge, go to IDLE. in_ready=0 in EXEC and DONE.
- acc_clr:
  - Sets acc=0 at the edge from any state.
  - If it coincides with an ACC capture in EXEC, the clear wins: acc=0, but out_sum still reports the sum.
  - Requests latched before the clear use the old acc value.
- Add/sub arithmetic is modulo 2^32. Carry-out is never folded into acc.
- Reserved mode 3 behaves exactly like ADD.

## Timing
- Reset (asynchronous, rst_n=0):
  - state=IDLE.
  - add_a, add_b, add_cin, out_sum, out_cout, out_ovf, acc all 0.
  - out_zero=1, out_valid=0, in_ready=1 after reset.
- Reset asserted mid-EXEC or mid-DONE drops the pending result. No out_valid follows reset release.
- Latency: request accepted at edge N, out_valid high from after edge N+1, result visible in cycle N+2.
- Peak throughput: one result per 3 cycles with out_ready tied high.
- out_ready low holds DONE indefinitely with no changes on out_*. in_valid during EXEC/DONE is not accepted; the upstream must hold the request.
- in_* and in_mode are sampled only at the accept edge. Later changes have no effect on an in-flight operation.
- add_a/add_b/add_cin are registered outputs, stable for the whole EXEC cycle.

## Test plan
- Reset then ADD a=0xFFFFFFFF, b=0x00000001, cin=0 -> out_sum=0, out_cout=1, out_zero=1, out_ovf=0, out_valid in cycle N+2.
- SUB a=0x80000000, b=1 -> out_sum=0x7FFFFFFF, out_ovf=1, out_cout=1. ADD a=b=0x7FFFFFFF -> out_sum=0xFFFFFFFE, out_ovf=1, out_cout=0.
- acc_clr, then ACC b=5, cin=0, then ACC b=7, cin=1 -> out_sum 5 then 13, acc=13. acc_clr in the EXEC cycle of a third ACC -> out_sum reported, acc=0.
- Backpressure: out_ready=0 for 10 cycles in DONE while in_valid is held high with new operands -> out_* stable, in_ready=0. Release -> IDLE, the new request is accepted next edge.
- Assert rst_n=0 during EXEC of ADD 3+4 -> no out_valid, acc=0, in_ready=1 immediately after release.
- Randomized back-to-back ADD/SUB/ACC with random out_ready against a reference model -> sums, flags and acc match every result.
